// File: rtl/reg_bank_if.sv
// Bus-side signal bundle for reg_bank: write/op port, read port and status flags.
interface reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             load;
  logic             op_en;
  logic [1:0]       op;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] reg_in;
  logic             enable;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] reg_out;
  logic             out_valid;
  logic             carry;
  logic             zero;

  modport master (
    output load, op_en, op, wr_addr, reg_in, enable, rd_addr,
    input  reg_out, out_valid, carry, zero
  );

  modport slave (
    input  load, op_en, op, wr_addr, reg_in, enable, rd_addr,
    output reg_out, out_valid, carry, zero
  );
endinterface

// File: rtl/reg_bank.sv
// Addressable register bank with in-place INC/DEC/SHL/SHR, carry/zero flags
// and a registered, write-first read port.
module reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  reg_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  // Address bound one bit wider so DEPTH itself is representable.
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] reg_out_q, reg_out_d;
  logic             out_valid_q, out_valid_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_active;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_result;
  logic             wr_carry;

  // Fetch the target entry and compute the write result and its carry; load wins over op.
  always_comb begin
    wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
    wr_old      = '0;
    if (wr_in_range) wr_old = mem_q[bus.wr_addr];
    wr_result = wr_old;
    wr_carry  = 1'b0;
    if (bus.load) begin
      wr_result = bus.reg_in;
      wr_carry  = 1'b0;
    end else begin
      case (bus.op)
        OP_INC: begin
          wr_result = wr_old + WIDTH'(1);
          wr_carry  = &wr_old;
        end
        OP_DEC: begin
          wr_result = wr_old - WIDTH'(1);
          wr_carry  = ~|wr_old;
        end
        OP_SHL: begin
          wr_result = {wr_old[WIDTH-2:0], 1'b0};
          wr_carry  = wr_old[WIDTH-1];
        end
        default: begin
          wr_result = {1'b0, wr_old[WIDTH-1:1]};
          wr_carry  = wr_old[0];
        end
      endcase
    end
    // Out-of-range writes leave entries and flags untouched.
    wr_active = (bus.load || bus.op_en) && wr_in_range;
  end

  // Next state: single-entry update, flags, and read of the post-write contents (bypass).
  always_comb begin
    mem_d       = mem_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    reg_out_d   = reg_out_q;
    out_valid_d = bus.enable;
    rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);
    if (wr_active) begin
      mem_d[bus.wr_addr] = wr_result;
      carry_d            = wr_carry;
      zero_d             = (wr_result == '0);
    end
    if (bus.enable) begin
      reg_out_d = '0;
      if (rd_in_range) reg_out_d = mem_d[bus.rd_addr];
    end
  end

  // State registers; async reset clears the bank and leaves zero set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      reg_out_q   <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      mem_q       <= mem_d;
      reg_out_q   <= reg_out_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.reg_out   = reg_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus a randomized run
// against an arithmetic reference model; a second 3x4-bit instance covers
// out-of-range addresses.
module tb_reg_bank;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  // reference model for instance A (WIDTH=8, DEPTH=4)
  int m_mem [4];
  int m_out;
  bit m_valid;
  bit m_carry;
  bit m_zero;

  reg_bank_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
  reg_bank_if #(.WIDTH(4), .DEPTH(3)) bus_b ();

  reg_bank #(.WIDTH(8), .DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  reg_bank #(.WIDTH(4), .DEPTH(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit ld, input bit opn, input int opc, input int wa,
                         input int din, input bit en, input int ra);
    bus_a.load    = ld;
    bus_a.op_en   = opn;
    bus_a.op      = 2'(opc);
    bus_a.wr_addr = 2'(wa);
    bus_a.reg_in  = 8'(din);
    bus_a.enable  = en;
    bus_a.rd_addr = 2'(ra);
  endtask

  task automatic drive_b(input bit ld, input bit opn, input int opc, input int wa,
                         input int din, input bit en, input int ra);
    bus_b.load    = ld;
    bus_b.op_en   = opn;
    bus_b.op      = 2'(opc);
    bus_b.wr_addr = 2'(wa);
    bus_b.reg_in  = 4'(din);
    bus_b.enable  = en;
    bus_b.rd_addr = 2'(ra);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 0;
    m_out = 0; m_valid = 0; m_carry = 0; m_zero = 1;
  endtask

  // Spec rules in plain integer arithmetic; the read sees the bank after the write.
  task automatic model_apply(input bit ld, input bit opn, input int opc, input int wa,
                             input int din, input bit en, input int ra);
    int old, res;
    bit c;
    if (ld || opn) begin
      old = m_mem[wa];
      res = old;
      c   = 0;
      if (ld) begin
        res = din; c = 0;
      end else begin
        case (opc)
          0: begin res = (old + 1) % 256;   c = (old == 255); end
          1: begin res = (old + 255) % 256; c = (old == 0);   end
          2: begin res = (old * 2) % 256;   c = (old >= 128); end
          default: begin res = old / 2;     c = (old % 2 == 1); end
        endcase
      end
      m_mem[wa] = res;
      m_carry   = c;
      m_zero    = (res == 0);
    end
    if (en) m_out = m_mem[ra];
    m_valid = en;
  endtask

  task automatic test_reset();
    tests_run++; if (bus_a.reg_out !== 8'h00) begin tests_failed++; $display("FAIL reset.reg_out got=%h exp=00", bus_a.reg_out); end
    tests_run++; if (bus_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset.out_valid got=%b exp=0", bus_a.out_valid); end
    tests_run++; if (bus_a.carry !== 1'b0) begin tests_failed++; $display("FAIL reset.carry got=%b exp=0", bus_a.carry); end
    tests_run++; if (bus_a.zero !== 1'b1) begin tests_failed++; $display("FAIL reset.zero got=%b exp=1", bus_a.zero); end
    // populate state, then reset mid-cycle
    drive_a(1, 0, 0, 1, 8'hFF, 0, 0); tick();
    drive_a(1, 0, 0, 0, 8'h3C, 1, 0); tick();
    tests_run++; if (bus_a.reg_out !== 8'h3C) begin tests_failed++; $display("FAIL reset.pre_load got=%h exp=3c", bus_a.reg_out); end
    drive_a(0, 1, 0, 1, 0, 1, 0);   // INC on FF -> carry set before reset
    tick();
    tests_run++; if (bus_a.carry !== 1'b1) begin tests_failed++; $display("FAIL reset.pre_carry got=%b exp=1", bus_a.carry); end
    drive_a(0, 1, 2, 0, 0, 1, 0);   // SHL 3C -> 78, zero clear
    tick();
    #2 rst = 1'b1;
    #1;
    tests_run++; if (bus_a.reg_out !== 8'h00) begin tests_failed++; $display("FAIL reset.async_reg_out got=%h exp=00", bus_a.reg_out); end
    tests_run++; if (bus_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset.async_valid got=%b exp=0", bus_a.out_valid); end
    tests_run++; if (bus_a.carry !== 1'b0) begin tests_failed++; $display("FAIL reset.async_carry got=%b exp=0", bus_a.carry); end
    tests_run++; if (bus_a.zero !== 1'b1) begin tests_failed++; $display("FAIL reset.async_zero got=%b exp=1", bus_a.zero); end
    drive_a(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      drive_a(0, 0, 0, 0, 0, 1, a); tick();
      tests_run++; if (bus_a.reg_out !== 8'h00 || bus_a.out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL reset.read_entry%0d got=%h/%b exp=00/1", a, bus_a.reg_out, bus_a.out_valid);
      end
    end
    drive_a(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_read();
    drive_a(1, 0, 0, 2, 8'hA5, 0, 0); tick();
    tests_run++; if (bus_a.carry !== 1'b0 || bus_a.zero !== 1'b0) begin
      tests_failed++; $display("FAIL load_read.flags got=c%b z%b exp=c0 z0", bus_a.carry, bus_a.zero);
    end
    drive_a(0, 0, 0, 0, 0, 1, 2); tick();
    tests_run++; if (bus_a.reg_out !== 8'hA5 || bus_a.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL load_read.read got=%h/%b exp=a5/1", bus_a.reg_out, bus_a.out_valid);
    end
    drive_a(0, 0, 0, 0, 0, 0, 1); tick();
    tests_run++; if (bus_a.reg_out !== 8'hA5 || bus_a.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL load_read.hold got=%h/%b exp=a5/0", bus_a.reg_out, bus_a.out_valid);
    end
  endtask

  task automatic test_inc_wrap();
    drive_a(1, 0, 0, 1, 8'hFF, 0, 0); tick();
    drive_a(0, 1, 0, 1, 0, 1, 1); tick();
    tests_run++; if (bus_a.reg_out !== 8'h00 || bus_a.carry !== 1'b1 || bus_a.zero !== 1'b1) begin
      tests_failed++; $display("FAIL inc_wrap.inc got=%h c%b z%b exp=00 c1 z1", bus_a.reg_out, bus_a.carry, bus_a.zero);
    end
    drive_a(0, 1, 1, 1, 0, 1, 1); tick();
    tests_run++; if (bus_a.reg_out !== 8'hFF || bus_a.carry !== 1'b1 || bus_a.zero !== 1'b0) begin
      tests_failed++; $display("FAIL inc_wrap.dec got=%h c%b z%b exp=ff c1 z0", bus_a.reg_out, bus_a.carry, bus_a.zero);
    end
    drive_a(0, 1, 1, 1, 0, 1, 1); tick();
    tests_run++; if (bus_a.reg_out !== 8'hFE || bus_a.carry !== 1'b0) begin
      tests_failed++; $display("FAIL inc_wrap.dec2 got=%h c%b exp=fe c0", bus_a.reg_out, bus_a.carry);
    end
    drive_a(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_shifts();
    drive_a(1, 0, 0, 0, 8'h81, 0, 0); tick();
    drive_a(0, 1, 2, 0, 0, 1, 0); tick();
    tests_run++; if (bus_a.reg_out !== 8'h02 || bus_a.carry !== 1'b1 || bus_a.zero !== 1'b0) begin
      tests_failed++; $display("FAIL shifts.shl got=%h c%b z%b exp=02 c1 z0", bus_a.reg_out, bus_a.carry, bus_a.zero);
    end
    drive_a(0, 1, 3, 0, 0, 1, 0); tick();
    tests_run++; if (bus_a.reg_out !== 8'h01 || bus_a.carry !== 1'b0 || bus_a.zero !== 1'b0) begin
      tests_failed++; $display("FAIL shifts.shr1 got=%h c%b z%b exp=01 c0 z0", bus_a.reg_out, bus_a.carry, bus_a.zero);
    end
    drive_a(0, 1, 3, 0, 0, 1, 0); tick();
    tests_run++; if (bus_a.reg_out !== 8'h00 || bus_a.carry !== 1'b1 || bus_a.zero !== 1'b1) begin
      tests_failed++; $display("FAIL shifts.shr2 got=%h c%b z%b exp=00 c1 z1", bus_a.reg_out, bus_a.carry, bus_a.zero);
    end
    // no write: flags hold
    drive_a(0, 0, 0, 0, 0, 0, 0); tick();
    tests_run++; if (bus_a.carry !== 1'b1 || bus_a.zero !== 1'b1) begin
      tests_failed++; $display("FAIL shifts.flag_hold got=c%b z%b exp=c1 z1", bus_a.carry, bus_a.zero);
    end
  endtask

  task automatic test_priority();
    drive_a(1, 1, 0, 3, 8'h10, 1, 3); tick();
    tests_run++; if (bus_a.reg_out !== 8'h10 || bus_a.carry !== 1'b0 || bus_a.zero !== 1'b0) begin
      tests_failed++; $display("FAIL priority.bypass got=%h c%b z%b exp=10 c0 z0", bus_a.reg_out, bus_a.carry, bus_a.zero);
    end
    drive_a(0, 0, 0, 0, 0, 1, 3); tick();
    tests_run++; if (bus_a.reg_out !== 8'h10) begin
      tests_failed++; $display("FAIL priority.entry3 got=%h exp=10", bus_a.reg_out);
    end
  endtask

  task automatic test_back_to_back();
    drive_a(1, 0, 0, 2, 8'h01, 0, 0); tick();
    for (int k = 1; k <= 3; k++) begin
      drive_a(0, 1, 2, 2, 0, 1, 2); tick();
      tests_run++; if (bus_a.reg_out !== 8'(1 << k) || bus_a.out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL back_to_back.shl%0d got=%h/%b exp=%h/1", k, bus_a.reg_out, bus_a.out_valid, 8'(1 << k));
      end
    end
    drive_a(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit ld, opn, en;
    int opc, wa, din, ra;
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    drive_a(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      ld  = ($urandom_range(0, 3) == 0);
      opn = $urandom_range(0, 1);
      opc = $urandom_range(0, 3);
      wa  = $urandom_range(0, 3);
      din = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      en  = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, 3);
      drive_a(ld, opn, opc, wa, din, en, ra);
      model_apply(ld, opn, opc, wa, din, en, ra);
      tick();
      tests_run++; if (bus_a.reg_out !== 8'(m_out) || bus_a.out_valid !== m_valid ||
                       bus_a.carry !== m_carry || bus_a.zero !== m_zero) begin
        tests_failed++;
        $display("FAIL random[%0d] got=%h/%b c%b z%b exp=%h/%b c%b z%b", n, bus_a.reg_out,
                 bus_a.out_valid, bus_a.carry, bus_a.zero, 8'(m_out), m_valid, m_carry, m_zero);
      end
    end
    drive_a(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_small();
    drive_b(1, 0, 0, 0, 4'h5, 0, 0); tick();
    tests_run++; if (bus_b.carry !== 1'b0 || bus_b.zero !== 1'b0) begin
      tests_failed++; $display("FAIL small.load_flags got=c%b z%b exp=c0 z0", bus_b.carry, bus_b.zero);
    end
    drive_b(1, 0, 0, 3, 4'h0, 1, 0); tick();
    tests_run++; if (bus_b.zero !== 1'b0 || bus_b.carry !== 1'b0 || bus_b.reg_out !== 4'h5) begin
      tests_failed++; $display("FAIL small.oob_load got=%h c%b z%b exp=5 c0 z0", bus_b.reg_out, bus_b.carry, bus_b.zero);
    end
    drive_b(0, 1, 1, 3, 0, 0, 0); tick();
    tests_run++; if (bus_b.carry !== 1'b0 || bus_b.zero !== 1'b0) begin
      tests_failed++; $display("FAIL small.oob_op got=c%b z%b exp=c0 z0", bus_b.carry, bus_b.zero);
    end
    drive_b(0, 0, 0, 0, 0, 1, 3); tick();
    tests_run++; if (bus_b.reg_out !== 4'h0 || bus_b.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL small.oob_read got=%h/%b exp=0/1", bus_b.reg_out, bus_b.out_valid);
    end
    drive_b(0, 1, 2, 0, 0, 1, 0); tick();
    tests_run++; if (bus_b.reg_out !== 4'hA || bus_b.carry !== 1'b0) begin
      tests_failed++; $display("FAIL small.shl1 got=%h c%b exp=a c0", bus_b.reg_out, bus_b.carry);
    end
    drive_b(0, 1, 2, 0, 0, 1, 0); tick();
    tests_run++; if (bus_b.reg_out !== 4'h4 || bus_b.carry !== 1'b1) begin
      tests_failed++; $display("FAIL small.shl2 got=%h c%b exp=4 c1", bus_b.reg_out, bus_b.carry);
    end
    drive_b(1, 0, 0, 2, 4'hF, 0, 0); tick();
    drive_b(0, 1, 0, 2, 0, 1, 2); tick();
    tests_run++; if (bus_b.reg_out !== 4'h0 || bus_b.carry !== 1'b1 || bus_b.zero !== 1'b1) begin
      tests_failed++; $display("FAIL small.inc_wrap got=%h c%b z%b exp=0 c1 z1", bus_b.reg_out, bus_b.carry, bus_b.zero);
    end
    drive_b(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_load_read();
    test_inc_wrap();
    test_shifts();
    test_priority();
    test_back_to_back();
    test_small();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
